// File: rtl/i2s_tx_dsp_unpacker.sv
// Sample unpacker and elastic word buffer feeding the I2S/DSP TX channel.
// Buffers 32-bit uDMA words and hands out 8/16/32-bit extended samples.
module i2s_tx_dsp_unpacker #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       sck_i,
  input  logic                       rstn_i,
  input  logic                       cfg_en_i,
  input  logic [1:0]                 cfg_word_size_i,
  input  logic                       cfg_sign_ext_i,
  input  logic [31:0]                data_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  output logic [31:0]                sample_o,
  output logic                       sample_valid_o,
  input  logic                       sample_ready_i,
  output logic                       underrun_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   h_word;
  logic          h_valid;
  logic [1:0]    h_idx;
  logic          started;
  logic          underrun_q;

  logic [1:0]    last_idx;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          consume;
  logic          last;
  logic [7:0]    lane8;
  logic [15:0]   lane16;

  // Handshake and FIFO control decode
  always_comb begin
    last_idx = 2'd0;
    case (cfg_word_size_i)
      2'b00:   last_idx = 2'd3;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd0;
    endcase
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    // Reset gates ready so the port reads idle the instant reset asserts
    data_ready_o = rstn_i & cfg_en_i & ~full;
    push         = data_valid_i & data_ready_o;
    consume      = h_valid & sample_ready_i;
    // An index beyond the current size (after a size change) counts as last
    last         = (h_idx >= last_idx);
    pop          = cfg_en_i & ~empty & (~h_valid | (consume & last));
  end

  // Lane select and sign/zero extension from the holding register
  always_comb begin
    lane8    = h_word[{h_idx, 3'b000} +: 8];
    lane16   = h_word[{h_idx[0], 4'b0000} +: 16];
    sample_o = h_word;
    case (cfg_word_size_i)
      2'b00:   sample_o = {{24{cfg_sign_ext_i & lane8[7]}}, lane8};
      2'b01:   sample_o = {{16{cfg_sign_ext_i & lane16[15]}}, lane16};
      default: sample_o = h_word;
    endcase
  end

  // Word storage; contents need no reset since count gates every read
  always_ff @(posedge sck_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // Pointers, count, holding register, started flag and underrun pulse
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      h_word     <= '0;
      h_valid    <= 1'b0;
      h_idx      <= 2'd0;
      started    <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!cfg_en_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      h_valid    <= 1'b0;
      h_idx      <= 2'd0;
      started    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop) begin
        h_word  <= mem[rd_ptr];
        h_valid <= 1'b1;
        h_idx   <= 2'd0;
      end else if (consume) begin
        if (last) h_valid <= 1'b0;
        else      h_idx   <= h_idx + 2'd1;
      end
      if (consume) started <= 1'b1;
      underrun_q <= started & sample_ready_i & ~h_valid;
    end
  end

  assign sample_valid_o = h_valid;
  assign underrun_o     = underrun_q;
  assign fill_o         = count;

endmodule
